altera_tse_gxb_aligned_txsync: RTL and testbench

Transmit-side counterpart of the GXB receive alignment stage in the 1000BASE-X PCS. Sits between the PCS transmit encoder output and the Alt2gxb/Alt4gxb transmitter inputs. It holds the transceiver in /I2/ idle after reset or loss of TX ready. It switches to PCS data only on an even code-group boundary. Output latency is pipelined per device family.

---
 rtl/altera_tse_gxb_txsync_pkg.sv | 23 ++
 rtl/altera_tse_gxb_tx_pipe.sv | 26 ++
 rtl/altera_tse_gxb_aligned_txsync.sv | 102 ++++++++++
 tb/tb_altera_tse_gxb_aligned_txsync.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/altera_tse_gxb_txsync_pkg.sv
// Shared constants, state encoding and family-to-latency mapping for the
// GXB transmit alignment stage.
package altera_tse_gxb_txsync_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D16_2 = 8'h50;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ALIGN = 2'd1,
        PASS  = 2'd2
    } state_t;

    // Families with the deeper transmitter interface need a second register stage.
    function automatic int lat_for_family(input string family);
        if (family == "STRATIXIV"   || family == "ARRIAIIGX"  ||
            family == "CYCLONEIVGX" || family == "HARDCOPYIV" ||
            family == "ARRIAIIGZ")
            return 2;
        return 1;
    endfunction

endpackage

// File: rtl/altera_tse_gxb_tx_pipe.sv
// Fixed-depth delay line for the transmit byte and its status bits;
// every stage clears asynchronously.
module altera_tse_gxb_tx_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/altera_tse_gxb_aligned_txsync.sv
// Holds the transmitter in /I2/ idle until TX ready has been stable, then
// hands over to PCS data on an even-slot K28.5.
module altera_tse_gxb_aligned_txsync
    import altera_tse_gxb_txsync_pkg::*;
#(
    parameter string DEVICE_FAMILY  = "ARRIAGX",
    parameter int    STARTUP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alt_tx_ready,
    input  logic [7:0] pcs_datain,
    input  logic       pcs_ctrlenable,
    output logic [7:0] alt_datain,
    output logic       alt_ctrlenable,
    output logic       alt_forcedisp,
    output logic       alt_dispval,
    output logic       txsync_aligned,
    output logic       txsync_misalign,
    output logic [1:0] state_dbg
);

    localparam int            LAT      = lat_for_family(DEVICE_FAMILY);
    localparam int            CW       = $clog2(STARTUP_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARTUP_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          p;
    logic          force_pending;

    logic          pcs_k28_5;
    logic          sel_pcs;
    logic          misalign;
    logic          entering_hold;
    logic          force_now;
    logic [7:0]    mux_data;
    logic          mux_ctrl;
    logic [12:0]   pipe_d;
    logic [12:0]   pipe_q;

    always_comb begin
        pcs_k28_5     = pcs_ctrlenable && (pcs_datain == K28_5);
        // A ready drop always forces the idle generator, even on the handover cycle.
        sel_pcs       = alt_tx_ready &&
                        ((state == PASS) || ((state == ALIGN) && !p && pcs_k28_5));
        misalign      = alt_tx_ready && (state == PASS) && p && pcs_k28_5;
        entering_hold = !alt_tx_ready && (state != HOLD);
        force_now     = !sel_pcs && !p && (force_pending || entering_hold);
        if (sel_pcs) begin
            mux_data = pcs_datain;
            mux_ctrl = pcs_ctrlenable;
        end else begin
            mux_data = p ? D16_2 : K28_5;
            mux_ctrl = !p;
        end
        pipe_d = {mux_data, mux_ctrl, force_now, 1'b0, sel_pcs, misalign};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HOLD;
            cnt           <= '0;
            p             <= 1'b0;
            force_pending <= 1'b1;
        end else begin
            // A misaligned K28.5 becomes slot 0, so the next byte is slot 1.
            p <= misalign ? 1'b1 : ~p;
            if (force_now)          force_pending <= 1'b0;
            else if (entering_hold) force_pending <= 1'b1;
            if (!alt_tx_ready) begin
                state <= HOLD;
                cnt   <= '0;
            end else begin
                case (state)
                    HOLD: begin
                        if (cnt == CNT_LAST) state <= ALIGN;
                        else                 cnt   <= cnt + 1'b1;
                    end
                    ALIGN:   if (sel_pcs) state <= PASS;
                    PASS:    state <= PASS;
                    default: state <= HOLD;
                endcase
            end
        end
    end

    altera_tse_gxb_tx_pipe #(
        .DEPTH (LAT),
        .W     (13)
    ) u_pipe (
        .clk   (clk),
        .reset (reset),
        .d     (pipe_d),
        .q     (pipe_q)
    );

    assign {alt_datain, alt_ctrlenable, alt_forcedisp, alt_dispval,
            txsync_aligned, txsync_misalign} = pipe_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_altera_tse_gxb_aligned_txsync.sv
// Drives an ARRIAGX (LAT=1) and a STRATIXIV (LAT=2) instance from one
// vector table and checks both against hand-computed transmit bytes.
module tb_altera_tse_gxb_aligned_txsync;

    typedef struct {
        logic        rdy;
        logic [7:0]  pd;
        logic        pc;
        logic [12:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [12:0] exp_q1[$];
    logic [12:0] exp_q2[$];
    int          n_pass  = 0;
    int          n_total = 0;

    logic       clk            = 1'b0;
    logic       reset          = 1'b1;
    logic       alt_tx_ready   = 1'b0;
    logic [7:0] pcs_datain     = 8'h00;
    logic       pcs_ctrlenable = 1'b0;

    logic [7:0] a_d, b_d;
    logic       a_c, a_f, a_v, a_al, a_m;
    logic       b_c, b_f, b_v, b_al, b_m;
    logic [1:0] a_st, b_st;
    logic [12:0] a_out, b_out;

    assign a_out = {a_d, a_c, a_f, a_v, a_al, a_m};
    assign b_out = {b_d, b_c, b_f, b_v, b_al, b_m};

    always #5 clk = ~clk;

    altera_tse_gxb_aligned_txsync #(
        .DEVICE_FAMILY  ("ARRIAGX"),
        .STARTUP_CYCLES (4)
    ) dut_a (
        .clk             (clk),
        .reset           (reset),
        .alt_tx_ready    (alt_tx_ready),
        .pcs_datain      (pcs_datain),
        .pcs_ctrlenable  (pcs_ctrlenable),
        .alt_datain      (a_d),
        .alt_ctrlenable  (a_c),
        .alt_forcedisp   (a_f),
        .alt_dispval     (a_v),
        .txsync_aligned  (a_al),
        .txsync_misalign (a_m),
        .state_dbg       (a_st)
    );

    altera_tse_gxb_aligned_txsync #(
        .DEVICE_FAMILY  ("STRATIXIV"),
        .STARTUP_CYCLES (4)
    ) dut_b (
        .clk             (clk),
        .reset           (reset),
        .alt_tx_ready    (alt_tx_ready),
        .pcs_datain      (pcs_datain),
        .pcs_ctrlenable  (pcs_ctrlenable),
        .alt_datain      (b_d),
        .alt_ctrlenable  (b_c),
        .alt_forcedisp   (b_f),
        .alt_dispval     (b_v),
        .txsync_aligned  (b_al),
        .txsync_misalign (b_m),
        .state_dbg       (b_st)
    );

    function automatic logic [12:0] pk(input logic [7:0] d, input logic c,
                                       input logic f, input logic a, input logic m);
        return {d, c, f, 1'b0, a, m};
    endfunction

    task automatic add(input logic rdy, input logic [7:0] pd, input logic pc,
                       input logic [7:0] ed, input logic ec, input logic ef,
                       input logic ea, input logic em);
        vec_t v;
        v.rdy = rdy;
        v.pd  = pd;
        v.pc  = pc;
        v.exp = pk(ed, ec, ef, ea, em);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [12:0] got, input logic [12:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d]: got data=%h ctrl=%b fd=%b dv=%b al=%b mis=%b, expected data=%h ctrl=%b fd=%b dv=%b al=%b mis=%b",
                      name, idx, got[12:5], got[4], got[3], got[2], got[1], got[0],
                      exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    task automatic check_state(input string name, input logic [1:0] got,
                               input logic [1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got state=%0d, expected state=%0d", name, got, exp);
    endtask

    initial begin
        //  rdy  pcs        expected mux byte for this cycle (data ctrl fd al mis)
        add(1, 8'hBC, 1,  8'hBC, 1, 1, 0, 0);  // HOLD: first K28.5 forced
        add(1, 8'h50, 0,  8'h50, 0, 0, 0, 0);
        add(1, 8'hBC, 1,  8'hBC, 1, 0, 0, 0);
        add(1, 8'h50, 0,  8'h50, 0, 0, 0, 0);
        add(1, 8'h50, 0,  8'hBC, 1, 0, 0, 0);  // ALIGN, no PCS K28.5
        add(1, 8'hBC, 1,  8'h50, 0, 0, 0, 0);  // odd-slot K28.5 ignored
        add(1, 8'h50, 0,  8'hBC, 1, 0, 0, 0);
        add(1, 8'hBC, 1,  8'h50, 0, 0, 0, 0);
        add(1, 8'hBC, 1,  8'hBC, 1, 0, 1, 0);  // even-slot K28.5: PASS
        add(1, 8'h50, 0,  8'h50, 0, 0, 1, 0);
        add(1, 8'h11, 0,  8'h11, 0, 0, 1, 0);
        add(1, 8'h22, 0,  8'h22, 0, 0, 1, 0);
        add(1, 8'hBC, 1,  8'hBC, 1, 0, 1, 0);
        add(1, 8'hBC, 1,  8'hBC, 1, 0, 1, 1);  // odd-slot K28.5 in PASS
        add(1, 8'h50, 0,  8'h50, 0, 0, 1, 0);
        add(1, 8'hBC, 1,  8'hBC, 1, 0, 1, 0);  // new even slot: no pulse
        add(1, 8'h33, 0,  8'h33, 0, 0, 1, 0);
        add(0, 8'h44, 0,  8'hBC, 1, 1, 0, 0);  // one-cycle ready drop
        add(1, 8'hA5, 0,  8'h50, 0, 0, 0, 0);
        add(1, 8'hA5, 0,  8'hBC, 1, 0, 0, 0);
        add(1, 8'hA5, 0,  8'h50, 0, 0, 0, 0);
        add(1, 8'hA5, 0,  8'hBC, 1, 0, 0, 0);
        add(1, 8'h50, 0,  8'h50, 0, 0, 0, 0);  // ALIGN on odd slot
        add(0, 8'hBC, 1,  8'hBC, 1, 1, 0, 0);  // drop beats handover
        add(1, 8'h50, 0,  8'h50, 0, 0, 0, 0);
        add(1, 8'hBC, 1,  8'hBC, 1, 0, 0, 0);
        add(1, 8'h50, 0,  8'h50, 0, 0, 0, 0);
        add(1, 8'hBC, 1,  8'hBC, 1, 0, 0, 0);  // last HOLD cycle
        add(1, 8'h50, 0,  8'h50, 0, 0, 0, 0);
        add(1, 8'hBC, 1,  8'hBC, 1, 0, 1, 0);  // realigned
        add(1, 8'h66, 0,  8'h66, 0, 0, 1, 0);
        add(1, 8'h77, 0,  8'h77, 0, 0, 1, 0);
        add(1, 8'h50, 0,  8'h50, 0, 0, 1, 0);

        exp_q1.push_back(13'd0);
        exp_q2.push_back(13'd0);
        exp_q2.push_back(13'd0);

        alt_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < tbl.size(); n++) begin
            check("arriagx", n, a_out, exp_q1.pop_front());
            check("stratixiv", n, b_out, exp_q2.pop_front());
            alt_tx_ready   = tbl[n].rdy;
            pcs_datain     = tbl[n].pd;
            pcs_ctrlenable = tbl[n].pc;
            exp_q1.push_back(tbl[n].exp);
            exp_q2.push_back(tbl[n].exp);
            @(posedge clk);
            @(negedge clk);
        end
        for (int n = tbl.size(); exp_q2.size() > 0; n++) begin
            if (exp_q1.size() > 0) check("arriagx", n, a_out, exp_q1.pop_front());
            check("stratixiv", n, b_out, exp_q2.pop_front());
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset while passing PCS data.
        check_state("pass_before_reset", a_st, 2'd2);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_a", 0, a_out, 13'd0);
        check("async_reset_b", 0, b_out, 13'd0);
        check_state("async_reset_state_a", a_st, 2'd0);
        check_state("async_reset_state_b", b_st, 2'd0);
        @(negedge clk);
        reset          = 1'b0;
        alt_tx_ready   = 1'b1;
        pcs_datain     = 8'h50;
        pcs_ctrlenable = 1'b0;
        @(posedge clk); @(negedge clk);
        check("restart_a", 1, a_out, pk(8'hBC, 1, 1, 0, 0));
        check("restart_b", 1, b_out, 13'd0);
        @(posedge clk); @(negedge clk);
        check("restart_a", 2, a_out, pk(8'h50, 0, 0, 0, 0));
        check("restart_b", 2, b_out, pk(8'hBC, 1, 1, 0, 0));
        @(posedge clk); @(negedge clk);
        check_state("restart_hold_a", a_st, 2'd0);
        @(posedge clk); @(negedge clk);
        check_state("restart_align_a", a_st, 2'd1);
        check_state("restart_align_b", b_st, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
